tone_event_scheduler: RTL
=========================

# tone_event_scheduler

Sequences game sound effects onto the shared audio tone path. Accepts single-cycle event pulses from the game logic (wall bounce, paddle hit, score, game over), queues them one deep per class, arbitrates by fixed priority, and drives the tone selection and enable seen by the audio output module for a configurable duration per event. Sits between the game logic and the audio codec output stage, in the system clock domain.

## Interface
- TICK_DIV, 50000: clock cycles per duration tick (1 ms at 50 MHz); must be ≥ 1.
- DUR_WALL, 40: wall tone length in ticks, ≥ 1.
- DUR_PADDLE, 60: paddle tone length in ticks, ≥ 1.
- DUR_SCORE, 250: score tone length in ticks, ≥ 1.
- DUR_OVER, 800: game-over tone length in ticks, ≥ 1.
- GAP, 20: silence between queued tones in ticks; 0 means no gap.
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- evWall  in  1  wall-bounce event, one-cycle pulse.
- evPaddle  in  1  paddle-hit event, one-cycle pulse.
- evScore  in  1  point-scored event, one-cycle pulse.
- evOver  in  1  game-over event, one-cycle pulse.
- toneSelect  out  2  tone code: 00 wall, 01 paddle, 10 score, 11 game over.
- toneActive  out  1  1 while a tone is playing; the audio path is silent when 0.
- busy  out  1  1 when the FSM is not IDLE or any pending bit is set.

## Operation
- Pending bits pWall, pPaddle, pScore, pOver. An event pulse sets its bit at the sampling edge. Repeated pulses merge into the single bit. A launch clears the bit, except that a pulse arriving on the launch edge leaves the bit set.
- Priority, highest first: Over > Score > Paddle > Wall.
- FSM states: IDLE, PLAY, GAP.
- IDLE → PLAY when any bit is pending. The highest-priority pending event launches:
  - toneSelect is loaded.
  - The duration counter is loaded with DUR_x.
  - The tick prescaler is cleared.
  - That pending bit is cleared.
- PLAY:
  - The prescaler counts 0..TICK_DIV-1. At wrap, the duration counter decrements.
  - When the duration counter is at 1 and the prescaler wraps, the tone ends.
  - On tone end: go to GAP if GAP > 0 and a bit is pending; otherwise go to IDLE.
- Preemption: in PLAY, a pending bit of strictly higher priority than the current tone launches on the next edge. The counters restart and the FSM stays in PLAY with no gap. The preempted tone is dropped, not resumed. Equal or lower priority events wait.
- GAP: toneActive = 0 for GAP×TICK_DIV cycles, then launch as from IDLE. Any higher-priority arrival during GAP does not shorten it.
- Game over: launching Over clears pWall, pPaddle and pScore on the same edge. While the Over tone plays, lower events are still latched and play afterwards.
- toneSelect holds its last value in IDLE and GAP.

## Timing
- Reset values: state IDLE, all pending 0, toneSelect 00, toneActive 0, busy 0, counters 0.
- Latency from an event pulse at edge k with the FSM in IDLE: pending is visible after edge k. toneActive = 1 and toneSelect are valid after edge k+1.
- Tone length: toneActive is high for exactly DUR_x×TICK_DIV cycles.
- Back-to-back launch: with GAP = 0 and a bit pending at tone end, the next tone starts on the following edge with toneActive never dropping, so the tones are contiguous.
- Reset asserted mid-tone forces all reset values immediately (asynchronously). Events during reset are lost.
- Counter widths use $clog2 of the largest parameter. No arithmetic wrap is permitted.

## Configuration
- TONE_SCHED_MUTE_EN defined: adds input port mute (1 bit). While mute = 1:
  - All event pulses are ignored.
  - Pending bits are cleared.
  - The FSM returns to IDLE on the next edge, with toneActive = 0 from that edge.
  - On release, operation resumes from IDLE.
- Not defined: no mute port; events are always accepted.

## Test plan
Benches use TICK_DIV=4, DUR_WALL=2, DUR_PADDLE=3, DUR_SCORE=5, DUR_OVER=8, GAP=1.
- Reset then a single evWall pulse → toneActive rises 2 edges later, toneSelect = 00, stays high exactly 8 cycles, busy falls when back in IDLE.
- evWall and evPaddle in the same cycle → paddle (01) plays 12 cycles, then 4 silent cycles, then wall (00) plays 8 cycles.
- evWall, then evScore 3 cycles into the wall tone → toneSelect switches to 10 on the next edge with no gap, plays 20 cycles, and the wall tone does not resume.
- evScore, then evWall and evPaddle during the score tone, then evOver → Over (11) preempts and plays 32 cycles, pending wall and paddle are cleared, FSM returns to IDLE.
- Three evPaddle pulses during one paddle tone → exactly one further paddle tone plays after a 4-cycle gap.
- rst_n asserted mid-tone → toneActive 0 and busy 0 immediately. With TONE_SCHED_MUTE_EN: mute=1 mid-tone → toneActive 0 next edge, evOver during mute produces no tone.

Source files
------------

// File: rtl/tone_event_scheduler.sv
// tone_event_scheduler: queues game sound events one deep per class, arbitrates by
// fixed priority (Over > Score > Paddle > Wall) and drives the tone select/enable for
// a per-event duration, with optional silence between queued tones.
// Optional feature: define TONE_SCHED_MUTE_EN to add the mute input.
module tone_event_scheduler #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DUR_WALL   = 40,
  parameter int unsigned DUR_PADDLE = 60,
  parameter int unsigned DUR_SCORE  = 250,
  parameter int unsigned DUR_OVER   = 800,
  parameter int unsigned GAP        = 20
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       evWall,
  input  logic       evPaddle,
  input  logic       evScore,
  input  logic       evOver,
`ifdef TONE_SCHED_MUTE_EN
  input  logic       mute,
`endif
  output logic [1:0] toneSelect,
  output logic       toneActive,
  output logic       busy
);

  // Duration counter also times the gap, so it must hold the largest of all lengths.
  localparam int unsigned MaxWP  = (DUR_WALL > DUR_PADDLE) ? DUR_WALL : DUR_PADDLE;
  localparam int unsigned MaxSO  = (DUR_SCORE > DUR_OVER) ? DUR_SCORE : DUR_OVER;
  localparam int unsigned MaxDur = (MaxWP > MaxSO) ? MaxWP : MaxSO;
  localparam int unsigned DurMax = (MaxDur > GAP) ? MaxDur : GAP;
  localparam int unsigned DurW   = $clog2(DurMax + 1);
  localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [DurW-1:0] DurOne  = DurW'(1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e            r_state, w_state_next;
  logic [3:0]        r_pend, w_pend_next;   // bit index = tone code
  logic [1:0]        r_sel, w_sel_next;
  logic [DurW-1:0]   r_dur, w_dur_next;
  logic [PreW-1:0]   r_pre, w_pre_next;

  logic              w_mute;
  logic [3:0]        w_ev;
  logic [1:0]        w_top;
  logic              w_any;
  logic              w_wrap;
  logic              w_cnt_end;
  logic              w_launch;

`ifdef TONE_SCHED_MUTE_EN
  assign w_mute = mute;
`else
  assign w_mute = 1'b0;
`endif

  assign w_ev      = {evOver, evScore, evPaddle, evWall} & {4{~w_mute}};
  assign w_any     = |r_pend;
  assign w_wrap    = (r_pre == PreLast);
  assign w_cnt_end = w_wrap && (r_dur == DurOne);

  function automatic logic [DurW-1:0] dur_of(input logic [1:0] idx);
    logic [DurW-1:0] d;
    unique case (idx)
      2'd0:    d = DurW'(DUR_WALL);
      2'd1:    d = DurW'(DUR_PADDLE);
      2'd2:    d = DurW'(DUR_SCORE);
      default: d = DurW'(DUR_OVER);
    endcase
    return d;
  endfunction

  // Highest-priority pending event.
  always_comb begin
    w_top = 2'd0;
    if (r_pend[3])      w_top = 2'd3;
    else if (r_pend[2]) w_top = 2'd2;
    else if (r_pend[1]) w_top = 2'd1;
    else                w_top = 2'd0;
  end

  // Next-state logic: sequencing, preemption, launch and pending-bit bookkeeping.
  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_sel_next   = r_sel;
    w_dur_next   = r_dur;
    w_pre_next   = r_pre;
    w_launch     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_any) w_launch = 1'b1;
      end
      StPlay: begin
        if (w_any && (w_top > r_sel)) begin
          w_launch = 1'b1;
        end else if (w_cnt_end) begin
          if (w_any && (GAP != 0)) begin
            w_state_next = StGap;
            w_dur_next   = DurW'(GAP);
            w_pre_next   = '0;
          end else if (w_any) begin
            w_launch = 1'b1;             // contiguous back-to-back tone
          end else begin
            w_state_next = StIdle;
            w_dur_next   = '0;
            w_pre_next   = '0;
          end
        end else if (w_wrap) begin
          w_pre_next = '0;
          w_dur_next = r_dur - DurOne;
        end else begin
          w_pre_next = r_pre + PreW'(1);
        end
      end
      StGap: begin
        if (w_cnt_end) begin
          if (w_any) begin
            w_launch = 1'b1;
          end else begin
            w_state_next = StIdle;
            w_dur_next   = '0;
            w_pre_next   = '0;
          end
        end else if (w_wrap) begin
          w_pre_next = '0;
          w_dur_next = r_dur - DurOne;
        end else begin
          w_pre_next = r_pre + PreW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (w_launch) begin
      w_state_next       = StPlay;
      w_sel_next         = w_top;
      w_dur_next         = dur_of(w_top);
      w_pre_next         = '0;
      w_pend_next[w_top] = 1'b0;
      if (w_top == 2'd3) w_pend_next = '0;   // game over flushes lower events
    end

    // Pulses on the launch edge survive the clear.
    w_pend_next = w_pend_next | w_ev;

    if (w_mute) begin
      w_state_next = StIdle;
      w_pend_next  = '0;
      w_dur_next   = '0;
      w_pre_next   = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pend  <= '0;
      r_sel   <= 2'b00;
      r_dur   <= '0;
      r_pre   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_sel   <= w_sel_next;
      r_dur   <= w_dur_next;
      r_pre   <= w_pre_next;
    end
  end

  assign toneSelect = r_sel;
  assign toneActive = (r_state == StPlay);
  assign busy       = (r_state != StIdle) || w_any;

endmodule
